// File: rtl/proc_control.sv
// proc_control: instruction sequencer for the simple 16-bit processor datapath.
// A 2-bit time-step counter (T0..T3) steps fetch, mv, mvi, add and sub.
// All outputs are combinational from (state, i_ir, i_run, i_gnz, i_reset).
//
// Optional feature macro: PROC_CONTROL_MVNZ_EN (opcode 101 becomes mvnz rx,ry;
// without it, opcode 101 is a NOP and i_gnz is unused).
//
// Ports:
//   i_clock     rising-edge clock
//   i_reset     synchronous active-high reset
//   i_run       start request, sampled only in T0
//   i_ir        IR contents {opcode[8:6], rx[5:3], ry[2:0]}
//   i_gnz       G register non-zero flag (mvnz only)
//   o_select    bus mux code (IR, r0-r7, G, DIN, rx-indexed, ry-indexed)
//   o_rx, o_ry  {1'b0, rx} / {1'b0, ry} to the mux index inputs
//   o_ir_in     IR load enable
//   o_r_in      one-hot r0-r7 load enables
//   o_a_in      A load enable
//   o_g_in      G load enable
//   o_addsub    ALU mode (0 add, 1 sub)
//   o_done      final step of an instruction
module proc_control #(
  parameter int unsigned IR_W = 9
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_run,
  input  logic [IR_W-1:0] i_ir,
  input  logic            i_gnz,
  output logic [3:0]      o_select,
  output logic [3:0]      o_rx,
  output logic [3:0]      o_ry,
  output logic            o_ir_in,
  output logic [7:0]      o_r_in,
  output logic            o_a_in,
  output logic            o_g_in,
  output logic            o_addsub,
  output logic            o_done
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned NREG  = 8;

  localparam logic [SEL_W-1:0] SEL_IR   = 4'b0000;
  localparam logic [SEL_W-1:0] SEL_R7   = 4'b1000;
  localparam logic [SEL_W-1:0] SEL_G    = 4'b1001;
  localparam logic [SEL_W-1:0] SEL_DIN  = 4'b1010;
  localparam logic [SEL_W-1:0] SEL_RX   = 4'b1011;
  localparam logic [SEL_W-1:0] SEL_RY   = 4'b1100;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
`ifdef PROC_CONTROL_MVNZ_EN
  localparam logic [2:0] OP_MVNZ = 3'b101;
`endif

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]      w_op;
  logic [2:0]      w_rx;
  logic [2:0]      w_ry;
  logic            w_is_addsub;
  logic [NREG-1:0] w_rx_onehot;
  logic            w_unused;

  assign w_op        = i_ir[8:6];
  assign w_rx        = i_ir[5:3];
  assign w_ry        = i_ir[2:0];
  assign w_is_addsub = (w_op == OP_ADD) || (w_op == OP_SUB);
  assign w_rx_onehot = NREG'(1) << w_rx;

  assign o_rx = {1'b0, w_rx};
  assign o_ry = {1'b0, w_ry};

  // Upper IR bits (when IR_W > 9) and gnz (when mvnz is disabled) are not needed.
  assign w_unused = ^{i_gnz, i_ir};

  // The indexed mux path does not reach r7, so r7 is selected with its direct code.
  function automatic logic [SEL_W-1:0] src_sel(input logic [2:0] field,
                                               input logic [SEL_W-1:0] idx_code);
    return (field == 3'd7) ? SEL_R7 : idx_code;
  endfunction

  // Time-step register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= T0;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and control outputs
  always_comb begin
    w_next   = T0;
    o_select = SEL_IR;
    o_ir_in  = 1'b0;
    o_r_in   = '0;
    o_a_in   = 1'b0;
    o_g_in   = 1'b0;
    o_addsub = 1'b0;
    o_done   = 1'b0;

    // Reset keeps everything idle, including mid-instruction.
    if (!i_reset) begin
      unique case (r_state)
        T0: begin
          if (i_run) begin
            o_select = SEL_DIN;
            o_ir_in  = 1'b1;
            w_next   = T1;
          end
        end

        T1: begin
          case (w_op)
            OP_MV: begin
              o_select = src_sel(w_ry, SEL_RY);
              o_r_in   = w_rx_onehot;
              o_done   = 1'b1;
            end
            OP_MVI: begin
              o_select = SEL_DIN;
              o_r_in   = w_rx_onehot;
              o_done   = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              o_select = src_sel(w_rx, SEL_RX);
              o_a_in   = 1'b1;
              w_next   = T2;
            end
`ifdef PROC_CONTROL_MVNZ_EN
            OP_MVNZ: begin
              if (i_gnz) begin
                o_select = src_sel(w_ry, SEL_RY);
                o_r_in   = w_rx_onehot;
              end
              o_done = 1'b1;
            end
`endif
            default: begin
              o_done = 1'b1;
            end
          endcase
        end

        T2: begin
          // A non add/sub opcode here means IR changed underneath us: go idle.
          if (w_is_addsub) begin
            o_select = src_sel(w_ry, SEL_RY);
            o_g_in   = 1'b1;
            o_addsub = w_op[0];
            w_next   = T3;
          end
        end

        T3: begin
          if (w_is_addsub) begin
            o_select = SEL_G;
            o_r_in   = w_rx_onehot;
            o_done   = 1'b1;
          end
        end

        default: begin
          w_next = T0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control.sv
// Scoreboard bench for proc_control: each stimulus step pushes the expected
// output word; a monitor pops and compares on every falling edge.
module tb_proc_control;

  logic       clk;
  logic       reset;
  logic       run;
  logic [8:0] ir;
  logic       gnz;
  logic [3:0] select;
  logic [3:0] rx;
  logic [3:0] ry;
  logic       ir_in;
  logic [7:0] r_in;
  logic       a_in;
  logic       g_in;
  logic       addsub;
  logic       done;

  int n_checks;
  int n_fail;

  // {rx, ry, select, ir_in, r_in, a_in, g_in, addsub, done}
  logic [24:0] q_exp[$];
  string       q_name[$];

  proc_control #(.IR_W(9)) dut (
    .i_clock  (clk),
    .i_reset  (reset),
    .i_run    (run),
    .i_ir     (ir),
    .i_gnz    (gnz),
    .o_select (select),
    .o_rx     (rx),
    .o_ry     (ry),
    .o_ir_in  (ir_in),
    .o_r_in   (r_in),
    .o_a_in   (a_in),
    .o_g_in   (g_in),
    .o_addsub (addsub),
    .o_done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus its hand-computed expected outputs.
  task automatic step(input string name, input logic i_run_v, input logic i_rst_v,
                      input logic [8:0] i_ir_v, input logic i_gnz_v,
                      input logic [3:0] e_sel, input logic e_irin, input logic [7:0] e_rin,
                      input logic e_a, input logic e_g, input logic e_as, input logic e_done);
    logic [24:0] e;
    @(posedge clk);
    #1;
    run   = i_run_v;
    reset = i_rst_v;
    ir    = i_ir_v;
    gnz   = i_gnz_v;
    e = {1'b0, i_ir_v[5:3], 1'b0, i_ir_v[2:0], e_sel, e_irin, e_rin, e_a, e_g, e_as, e_done};
    q_exp.push_back(e);
    q_name.push_back(name);
  endtask

  // Monitor: outputs are combinational, so every cycle presents a result.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      logic [24:0] exp_v;
      logic [24:0] act_v;
      string       nm;
      exp_v = q_exp.pop_front();
      nm    = q_name.pop_front();
      act_v = {rx, ry, select, ir_in, r_in, a_in, g_in, addsub, done};
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s: got rx=%h ry=%h sel=%b ir_in=%b r_in=%b a=%b g=%b as=%b done=%b, want rx=%h ry=%h sel=%b ir_in=%b r_in=%b a=%b g=%b as=%b done=%b",
                 nm, act_v[24:21], act_v[20:17], act_v[16:13], act_v[12], act_v[11:4],
                 act_v[3], act_v[2], act_v[1], act_v[0],
                 exp_v[24:21], exp_v[20:17], exp_v[16:13], exp_v[12], exp_v[11:4],
                 exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
      end
    end
  end

  localparam logic [8:0] IR_MVI_R3   = 9'b001_011_000;
  localparam logic [8:0] IR_MV_R7_R3 = 9'b000_111_011;
  localparam logic [8:0] IR_ADD_1_2  = 9'b010_001_010;
  localparam logic [8:0] IR_SUB_0_7  = 9'b011_000_111;
  localparam logic [8:0] IR_ADD_7_0  = 9'b010_111_000;
  localparam logic [8:0] IR_OP110    = 9'b110_010_011;
  localparam logic [8:0] IR_MVNZ     = 9'b101_100_001;

  initial begin
    logic [7:0] mvnz_rin;
    logic [3:0] mvnz_sel;
    int         wait_cnt;
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    run   = 1'b1;
    ir    = 9'd0;
    gnz   = 1'b0;

    // Reset holds outputs idle even with run high.
    step("rst0", 1, 1, 9'd0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    step("rst1", 1, 1, 9'd0, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);

    // mvi r3 then mv r7,r3 with run held high
    step("mvi_fetch", 1, 0, 9'd0,        0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("mvi_t1",    1, 0, IR_MVI_R3,   0, 4'b1010, 0, 8'h08, 0, 0, 0, 1);
    step("mv_fetch",  1, 0, IR_MVI_R3,   0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("mv_t1",     1, 0, IR_MV_R7_R3, 0, 4'b1100, 0, 8'h80, 0, 0, 0, 1);

    // run low in T0: idle
    for (int i = 0; i < 3; i++)
      step("idle_run0", 0, 0, IR_MV_R7_R3, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);

    // add r1,r2; run dropped mid-instruction does not abort
    step("add_fetch", 1, 0, IR_MV_R7_R3, 0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("add_t1",    0, 0, IR_ADD_1_2,  0, 4'b1011, 0, 8'h00, 1, 0, 0, 0);
    step("add_t2",    0, 0, IR_ADD_1_2,  0, 4'b1100, 0, 8'h00, 0, 1, 0, 0);
    step("add_t3",    0, 0, IR_ADD_1_2,  0, 4'b1001, 0, 8'h02, 0, 0, 0, 1);
    step("add_after", 0, 0, IR_ADD_1_2,  0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);

    // sub r0,r7: r7 as ry uses direct code
    step("sub_fetch", 1, 0, IR_ADD_1_2, 0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("sub_t1",    1, 0, IR_SUB_0_7, 0, 4'b1011, 0, 8'h00, 1, 0, 0, 0);
    step("sub_t2",    1, 0, IR_SUB_0_7, 0, 4'b1000, 0, 8'h00, 0, 1, 1, 0);
    step("sub_t3",    1, 0, IR_SUB_0_7, 0, 4'b1001, 0, 8'h01, 0, 0, 0, 1);

    // add r7,r0 back-to-back: r7 as rx uses direct code
    step("add7_fetch", 1, 0, IR_SUB_0_7, 0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("add7_t1",    0, 0, IR_ADD_7_0, 0, 4'b1000, 0, 8'h00, 1, 0, 0, 0);
    step("add7_t2",    0, 0, IR_ADD_7_0, 0, 4'b1100, 0, 8'h00, 0, 1, 0, 0);
    step("add7_t3",    0, 0, IR_ADD_7_0, 0, 4'b1001, 0, 8'h80, 0, 0, 0, 1);

    // opcode 110 is a NOP, then idle indefinitely with run low
    step("nop_fetch", 1, 0, IR_ADD_7_0, 0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("nop_t1",    0, 0, IR_OP110,   0, 4'b0000, 0, 8'h00, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++)
      step("nop_idle", 0, 0, IR_OP110, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);

    // opcode 101 with gnz high and low
`ifdef PROC_CONTROL_MVNZ_EN
    mvnz_rin = 8'h10;
    mvnz_sel = 4'b1100;
`else
    mvnz_rin = 8'h00;
    mvnz_sel = 4'b0000;
`endif
    step("mvnz1_fetch", 1, 0, IR_OP110, 1, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("mvnz1_t1",    1, 0, IR_MVNZ,  1, mvnz_sel, 0, mvnz_rin, 0, 0, 0, 1);
    step("mvnz0_fetch", 1, 0, IR_MVNZ,  0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("mvnz0_t1",    0, 0, IR_MVNZ,  0, 4'b0000, 0, 8'h00, 0, 0, 0, 1);

    // reset for 2 cycles during T2 of an add
    step("rsta_fetch", 1, 0, IR_MVNZ,    0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("rsta_t1",    1, 0, IR_ADD_1_2, 0, 4'b1011, 0, 8'h00, 1, 0, 0, 0);
    step("rsta_t2rst", 1, 1, IR_ADD_1_2, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    step("rsta_rst2",  1, 1, IR_ADD_1_2, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    step("rsta_t0",    0, 0, IR_ADD_1_2, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    step("rsta_refet", 1, 0, IR_ADD_1_2, 0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("rsta_rt1",   0, 0, IR_ADD_1_2, 0, 4'b1011, 0, 8'h00, 1, 0, 0, 0);

    // IR corrupted to mv while in T2: idle, then back in T0 (fetch accepted)
    step("corr_t2",    1, 0, IR_MV_R7_R3, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);
    step("corr_fetch", 1, 0, IR_MV_R7_R3, 0, 4'b1010, 1, 8'h00, 0, 0, 0, 0);
    step("corr_mv_t1", 0, 0, IR_MV_R7_R3, 0, 4'b1100, 0, 8'h80, 0, 0, 0, 1);
    step("end_idle",   0, 0, IR_MV_R7_R3, 0, 4'b0000, 0, 8'h00, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    wait_cnt = 0;
    while (q_exp.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    @(posedge clk);
    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_control.md
# proc_control

Instruction sequencer for the simple 16-bit processor datapath. Each cycle it drives the bus multiplexer select code, the register/IR/A/G load enables and the ALU add/sub control. It fetches an instruction word from `din` into the IR, then steps the mv/mvi/add/sub sequences over up to four time steps (T0–T3). It asserts `done` on the final step of each instruction.

## Interface
- `IR_W`, default 9: IR field width; layout `{opcode[8:6], rx[5:3], ry[2:0]}`.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `run`  in  1  start request; sampled only in T0.
- `ir`  in  IR_W  current IR register contents, taken from the IR register output.
- `gnz`  in  1  G register non-zero flag; used only with `MVNZ_EN`.
- `select`  out  4  bus mux code:
  - 0000 IR
  - 0001–1000 r0–r7
  - 1001 G
  - 1010 DIN
  - 1011 rx-indexed
  - 1100 ry-indexed
- `rx`, `ry`  out  4  `{1'b0, ir[5:3]}` and `{1'b0, ir[2:0]}` to the mux index inputs.
- `ir_in`  out  1  IR load enable.
- `r_in`  out  8  one-hot register load enables for r0–r7.
- `a_in`, `g_in`  out  1  A and G load enables.
- `addsub`  out  1  ALU mode: 0 add, 1 sub.
- `done`  out  1  instruction complete.

## Operation
- State: a 2-bit time-step counter T0–T3. It is the only sequential element.
- All outputs are combinational from (state, `ir`, `run`, `gnz`).
- Idle outputs: `select` = 0000, every enable 0, `addsub` = 0, `done` = 0.
- T0:
  - `run` = 0: stay in T0 with idle outputs.
  - `run` = 1: `select` = 1010, `ir_in` = 1, next state T1. The IR captures `din` on that edge.
- Register source selection: for a register source field value 0–6, use the indexed code (1011 for rx, 1100 for ry). For value 7, use the direct code 1000. The mux index path does not cover r7.
- Opcode 000, mv rx,ry:
  - T1: source ry, `r_in[rx]` = 1, `done` = 1.
  - Next state T0.
- Opcode 001, mvi rx,#D:
  - T1: `select` = 1010, `r_in[rx]` = 1, `done` = 1.
  - Next state T0. The immediate word is on `din` during T1.
- Opcode 010 add / 011 sub:
  - T1: source rx, `a_in` = 1.
  - T2: source ry, `g_in` = 1, `addsub` = opcode[0].
  - T3: `select` = 1001, `r_in[rx]` = 1, `done` = 1.
  - Next state T0.
- Opcodes 100–111 (except 101 when `MVNZ_EN` is defined):
  - T1: `done` = 1, no enables asserted.
  - Next state T0. The instruction is treated as a NOP.
- `done` is high for exactly one cycle per instruction.
- `r_in` is always zero or one-hot.

## Timing
- Instruction latency, counted from the T0 cycle in which `run` = 1 to `done`:
  - mv, mvi, NOP: 2 cycles.
  - add, sub: 4 cycles.
- Back-to-back instructions: if `run` is held high, the next fetch occurs in the cycle after `done`. There are no bubble cycles.
- `run` is ignored in T1–T3. Dropping `run` mid-instruction does not abort it.
- Reset:
  - Next state forced to T0.
  - While `reset` = 1, all enables and `done` are forced to 0 and `select` = 0000. This applies even in the middle of an instruction.
  - The aborted instruction performs no further register writes.
- `reset` has priority over `run` in the same cycle.
- State value 2'b11 is reachable only for add/sub. For any other opcode in T2/T3 (IR corrupted externally), drive idle outputs and return to T0.

## Configuration
- `PROC_CONTROL_MVNZ_EN`:
  - Defined: opcode 101 is mvnz rx,ry. T1: if `gnz` = 1, source ry and `r_in[rx]` = 1; in both cases `done` = 1 and next state T0.
  - Undefined: opcode 101 is a NOP, and `gnz` is unused.

## Test plan
- Reset: assert `reset` for 2 cycles in T2 of an add. Required: no enables during reset; state T0 afterwards; `r_in` = 0 until the next fetch.
- mvi r3,#0x00AA then mv r7,r3 with `run` held high:
  - Cycle 1 (fetch): `ir_in` = 1, `select` = 1010.
  - Cycle 2 (mvi T1): `select` = 1010, `r_in` = 0000_1000, `done` = 1.
  - Cycle 3: fetch.
  - Cycle 4 (mv T1): `select` = 1100, `r_in` = 1000_0000, `done` = 1.
- add r1,r2 (ir = 010_001_010):
  - T1: `select` = 1011, `a_in` = 1.
  - T2: `select` = 1100, `g_in` = 1, `addsub` = 0.
  - T3: `select` = 1001, `r_in` = 0000_0010, `done` = 1.
- sub r0,r7 (ir = 011_000_111): T2 `select` = 1000 (direct r7), `addsub` = 1. add r7,r0: T1 `select` = 1000.
- Opcode 110 (ir = 110_010_011): T1 `done` = 1 with all enables 0, then back to T0. With `run` = 0 in T0: outputs stay idle indefinitely.
- `PROC_CONTROL_MVNZ_EN` (ir = 101_100_001):
  - Defined, `gnz` = 1: `r_in` = 0001_0000, `select` = 1100.
  - Defined, `gnz` = 0: `r_in` = 0.
  - Undefined: NOP for either value of `gnz`.
